// File: rtl/ids_dma.sv
// ids_dma: copies i_len 32-bit words from a PIM buffer region to a PIM region.
// Reads go out on port 0 and writes on port 1, both under one arbiter grant.
// Read data returns one cycle after an effective read and is staged in a
// 2-entry FIFO. Reads are throttled so that in-flight data always has a slot.
module ids_dma (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_src_addr,
    input  logic [31:0] i_dst_addr,
    input  logic [15:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_req_dma,
    input  logic        i_gnt_dma,
    output logic [31:0] o_dma_addr_0,
    output logic        o_dma_read_0,
    output logic        o_dma_write_0,
    output logic [3:0]  o_dma_size_0,
    output logic [31:0] o_dma_din_0,
    input  logic [31:0] i_dma_dout_0,
    output logic [31:0] o_dma_addr_1,
    output logic        o_dma_read_1,
    output logic        o_dma_write_1,
    output logic [3:0]  o_dma_size_1,
    output logic [31:0] o_dma_din_1,
    input  logic [31:0] i_dma_dout_1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] src_q, src_d;
    logic [29:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic        pend_q, pend_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [31:0] fifo0_q, fifo0_d;
    logic [31:0] fifo1_q, fifo1_d;

    logic        run;
    logic        eff;
    logic        write_now;
    logic        read_now;
    logic [2:0]  occupancy;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic        unused_inputs;

    // The low address bits are always zero (word aligned) and port-1 read data is never used.
    assign unused_inputs = ^{i_dma_dout_1, i_src_addr[1:0], i_dst_addr[1:0]};

    // Bus-cycle qualification: effective cycle, write/read strobes and current addresses.
    always_comb begin
        run       = (state_q == ST_RUN);
        eff       = run && i_gnt_dma;
        write_now = eff && (fifo_cnt_q != 2'd0);
        occupancy = {1'b0, fifo_cnt_q} + {2'b00, pend_q} - {2'b00, write_now};
        read_now  = eff && (rd_cnt_q < len_q) && (occupancy < 3'd2);
        rd_addr   = {src_q, 2'b00} + {14'b0, rd_cnt_q, 2'b00};
        wr_addr   = {dst_q, 2'b00} + {14'b0, wr_cnt_q, 2'b00};
    end

    // Control FSM and transfer counters; start is only honoured in IDLE.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        pend_d   = read_now;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_len != 16'd0) begin
                        src_d    = i_src_addr[31:2];
                        dst_d    = i_dst_addr[31:2];
                        len_d    = i_len;
                        rd_cnt_d = 16'd0;
                        wr_cnt_d = 16'd0;
                        state_d  = ST_RUN;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (read_now) begin
                    rd_cnt_d = rd_cnt_q + 16'd1;
                end
                if (write_now) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                    if ((wr_cnt_q + 16'd1) == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-entry shift FIFO: entry 0 is always the head; returning read data is pushed unconditionally.
    always_comb begin
        fifo0_d    = fifo0_q;
        fifo1_d    = fifo1_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({pend_q, write_now})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) begin
                    fifo0_d = i_dma_dout_0;
                end else begin
                    fifo1_d = i_dma_dout_0;
                end
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                fifo0_d    = fifo1_q;
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    fifo0_d = i_dma_dout_0;
                end else begin
                    fifo0_d = fifo1_q;
                    fifo1_d = i_dma_dout_0;
                end
            end
            default: begin
                fifo_cnt_d = fifo_cnt_q;
            end
        endcase
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            src_q      <= 30'd0;
            dst_q      <= 30'd0;
            len_q      <= 16'd0;
            rd_cnt_q   <= 16'd0;
            wr_cnt_q   <= 16'd0;
            pend_q     <= 1'b0;
            fifo_cnt_q <= 2'd0;
            fifo0_q    <= 32'd0;
            fifo1_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            pend_q     <= pend_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo0_q    <= fifo0_d;
            fifo1_q    <= fifo1_d;
        end
    end

    // Output decode; every port output is zero outside RUN.
    always_comb begin
        o_busy        = (state_q != ST_IDLE);
        o_done        = (state_q == ST_DONE);
        o_req_dma     = run;
        o_dma_addr_0  = run ? rd_addr : 32'd0;
        o_dma_read_0  = read_now;
        o_dma_write_0 = 1'b0;
        o_dma_size_0  = read_now ? 4'b1111 : 4'b0000;
        o_dma_din_0   = 32'd0;
        o_dma_addr_1  = run ? wr_addr : 32'd0;
        o_dma_read_1  = 1'b0;
        o_dma_write_1 = write_now;
        o_dma_size_1  = write_now ? 4'b1111 : 4'b0000;
        o_dma_din_1   = run ? fifo0_q : 32'd0;
    end

endmodule

// File: doc/ids_dma.md
IDS_DMA -- requirements
Module: ids_dma

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset, i_clk and i_rst_n, as listed below.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  async active-low reset
- i_start  in  1  one-cycle start pulse; honoured only in IDLE
- i_src_addr  in  32  source base, PIM buffer region (0x2xxx_xxxx), word-aligned
- i_dst_addr  in  32  destination base, PIM region (0x4xxx_xxxx), word-aligned
- i_len  in  16  transfer length in 32-bit words
- o_busy  out  1  high from accepted start until the DONE cycle, inclusive
- o_done  out  1  one-cycle completion pulse
- o_req_dma  out  1  bus request to the DMEM-side arbiter
- i_gnt_dma  in  1  bus grant; effective cycle = o_req_dma && i_gnt_dma
- o_dma_addr_0 / o_dma_read_0 / o_dma_write_0 / o_dma_size_0 / o_dma_din_0  out  32/1/1/4/32  read port 0 (buffer)
- i_dma_dout_0  in  32  port-0 read data, valid the cycle after an effective read
- o_dma_addr_1 / o_dma_read_1 / o_dma_write_1 / o_dma_size_1 / o_dma_din_1  out  32/1/1/4/32  write port 1 (PIM)
- i_dma_dout_1  in  32  unused, ignored

Function
REQ-003 SHALL implement states IDLE, RUN, DONE.
REQ-004 IDLE: i_start with i_len!=0 SHALL latch i_src_addr[31:2], i_dst_addr[31:2] and i_len, clear rd_cnt and wr_cnt, and enter RUN next cycle.
REQ-005 IDLE: i_start with i_len==0 SHALL go directly to DONE; no bus request is raised.
REQ-006 i_start SHALL be ignored in RUN and DONE.
REQ-007 RUN: o_req_dma SHALL be 1 every cycle, including drain cycles with no pending reads.
REQ-008 Port addresses SHALL be o_dma_addr_0={src_q,2'b00}+4*rd_cnt and o_dma_addr_1={dst_q,2'b00}+4*wr_cnt, modulo 2^32 (wrap permitted, no error).
REQ-009 In IDLE and DONE, all port-0/port-1 outputs SHALL be 0.
REQ-010 Sizes SHALL be 4'b1111 whenever the matching strobe is 1, else 0. o_dma_write_0, o_dma_read_1 and o_dma_din_0 SHALL be constant 0.
REQ-011 A 2-entry data FIFO (count 0..2) and a pend_q flag SHALL exist. pend_q=1 means an effective read happened in the previous cycle.
REQ-012 While pend_q=1, i_dma_dout_0 SHALL be pushed into the FIFO at the clock edge, whether or not a grant is present.
REQ-013 Write: o_dma_write_1=1 iff the cycle is effective and count>0. o_dma_din_1 SHALL be the FIFO head. On the edge the head pops and wr_cnt increments.
REQ-014 Read: o_dma_read_0=1 iff the cycle is effective, rd_cnt<len_q, and (count + pend_q - write_now) < 2. On the edge rd_cnt increments and pend_q is set; otherwise pend_q is cleared.
REQ-015 Push and pop in the same edge SHALL leave count unchanged. Overflow SHALL be impossible under REQ-014; a bench assertion checks this.
REQ-016 With grant held continuously, the block SHALL sustain one write per cycle. The first write SHALL occur 2 cycles after the first read, so len words finish in len+2 RUN cycles.
REQ-017 Grant loss SHALL stall reads and writes only. Counters, FIFO contents and addresses SHALL be held, except for the REQ-012 push.
REQ-018 RUN SHALL go to DONE on the edge where wr_cnt reaches len_q.
REQ-019 DONE SHALL last exactly one cycle, with o_done=1, o_busy=1 and o_req_dma=0, then return to IDLE.

Reset
REQ-020 Reset SHALL force IDLE, with rd_cnt, wr_cnt, src_q, dst_q, len_q, pend_q, FIFO count and FIFO data all 0.
REQ-021 During reset, every output SHALL be 0.
REQ-022 Reset asserted mid-RUN SHALL abort the transfer without completing the pending write. No o_done pulse is produced.

Verification
REQ-023 Start src=0x2000_0000, dst=0x4000_0100, len=4, grant tied 1:
- reads at 0x2000_0000..0x2000_000C on consecutive cycles;
- writes of the returned data to 0x4000_0100..0x4000_010C, the first write 2 cycles after the first read;
- o_done pulses at RUN cycle 6.
REQ-024 len=0 start -> o_done one cycle after start; o_req_dma never asserts.
REQ-025 len=8 with grant dropped for 3 cycles after the 2nd read -> FIFO reaches count 2 with no overflow; after grant returns, all 8 words are written in order with correct data.
REQ-026 src=0xFFFF_FFF8, len=3 -> read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-027 Reset pulsed after 3 writes of a len=10 transfer -> all outputs 0, no o_done. A new start then runs normally from word 0.
REQ-028 i_start re-pulsed mid-RUN with different parameters -> ignored; the original transfer completes unchanged.
